// File: rtl/adder_arbiter_if.sv
// Request/response bundle of the shared-adder arbiter: N requesters issuing
// signed add/subtract operations and one tagged response channel.
interface adder_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_sub;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_sum;
    logic            rsp_cout;
    logic            rsp_overflow;
    logic            busy;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder among N requesters,
// plus the adder itself (4-bit lookahead groups with a lookahead carry chain).
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);
    logic [7:0] gg;
    logic [7:0] pp;
    logic [7:0] c3;
    logic [8:0] cg;

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        logic [3:0] g;
        logic [3:0] p;
        logic [3:1] c;
        assign g = a[4*gi +: 4] & b[4*gi +: 4];
        assign p = a[4*gi +: 4] ^ b[4*gi +: 4];
        assign c[1] = g[0] | (p[0] & cg[gi]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg[gi]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cg[gi]);
        assign gg[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        assign pp[gi] = &p;
        assign c3[gi] = c[3];
        assign sum[4*gi +: 4] = p ^ {c[3], c[2], c[1], cg[gi]};
    end

    // Group carries depend only on group generate/propagate, never on bit carries.
    always_comb begin
        cg    = '0;
        cg[0] = cin;
        for (int k = 0; k < 8; k++) begin
            cg[k+1] = gg[k] | (pp[k] & cg[k]);
        end
    end

    assign cout     = cg[8];
    assign overflow = c3[7] ^ cg[8];
endmodule

module adder_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

    state_t         state_reg, state_next;
    logic [IDW-1:0] last_reg;
    logic [IDW-1:0] grant_id;
    logic           grant_any;
    logic           accept;

    logic [31:0]    op_a_reg, op_b_reg;
    logic           op_sub_reg;
    logic [IDW-1:0] op_id_reg;

    logic [31:0]    sum_reg;
    logic           cout_reg, ovf_reg;
    logic [IDW-1:0] id_reg;

    logic [31:0]    adder_b;
    logic [31:0]    add_sum;
    logic           add_cout, add_ovf;

    // Search starts just after the last grant; the lowest offset with valid wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    assign accept = (state_reg == IDLE) && grant_any && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_id] = 1'b1;
        end
        bus.rsp_valid = (state_reg == RESP);
        bus.busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg   <= LAST_RST;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            op_sub_reg <= 1'b0;
            op_id_reg  <= '0;
        end else if (accept) begin
            last_reg   <= grant_id;
            op_a_reg   <= bus.req_a[32*int'(grant_id) +: 32];
            op_b_reg   <= bus.req_b[32*int'(grant_id) +: 32];
            op_sub_reg <= bus.req_sub[grant_id];
            op_id_reg  <= grant_id;
        end
    end

    // Subtraction is A + ~B + 1, which keeps the adder's overflow output valid.
    assign adder_b = op_sub_reg ? ~op_b_reg : op_b_reg;

    cla32 u_cla (
        .a        (op_a_reg),
        .b        (adder_b),
        .cin      (op_sub_reg),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            id_reg   <= '0;
        end else if (state_reg == EXEC) begin
            sum_reg  <= add_sum;
            cout_reg <= add_cout;
            ovf_reg  <= add_ovf;
            id_reg   <= op_id_reg;
        end
    end

    assign bus.rsp_id       = id_reg;
    assign bus.rsp_sum      = sum_reg;
    assign bus.rsp_cout     = cout_reg;
    assign bus.rsp_overflow = ovf_reg;
endmodule
